// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the execute/memory result stage: branch funct3
// encodings, the ALU control codes decode uses to set up compares, and the
// branch condition helper.
package alu_result_stage_pkg;

  // RISC-V conditional branch funct3 encodings.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  // ALU control codes. For branches, decode selects SUB (BEQ/BNE) or
  // SLT/SLTU (BLT/BGE/BLTU/BGEU), so the stage only inspects the zero flag
  // and the result LSB.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_SUB  = 4'd8
  } alu_ctrl_e;

  // Link address offset for jumps (pc + 4).
  localparam int unsigned INSN_BYTES = 4;

  // Branch condition from the ALU outputs. funct3 010/011 are not valid
  // branch encodings and never resolve taken.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       alu_zero,
                                       input logic       alu_lsb);
    logic cond;
    case (funct3)
      F3_BEQ:            cond = alu_zero;
      F3_BNE:            cond = ~alu_zero;
      F3_BLT,  F3_BLTU:  cond = alu_lsb;
      F3_BGE,  F3_BGEU:  cond = ~alu_lsb;
      default:           cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/alu_result_stage_branch_resolve.sv
// Combinational branch/jump resolution: decides whether the instruction
// redirects fetch and computes the redirect target.
module alu_result_stage_branch_resolve
  import alu_result_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            br_en,
  input  logic            jal,
  input  logic            jalr,
  input  logic            alu_zero,
  input  logic            alu_lsb,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_out,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic cond;

  // Jumps always redirect; jalr takes priority over jal for the target.
  always_comb begin
    cond  = branch_cond(funct3, alu_zero, alu_lsb);
    taken = jal | jalr | (br_en & cond);
    if (jalr) begin
      target = alu_out & ~XLEN'(1);
    end else begin
      target = pc + imm;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute/memory pipeline register directly after the ALU. Captures the ALU
// result with the instruction's control fields, resolves branches/jumps into
// a one-cycle fetch redirect, and counts retired ops and redirects.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  store_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             br_en,
  input  logic [2:0]       br_funct3,
  input  logic             jal,
  input  logic             jalr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [XLEN-1:0]  out_addr,
  output logic [XLEN-1:0]  out_store_data,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] cnt_retired,
  output logic [CNT_W-1:0] cnt_taken
);

  logic            capture;
  logic            retire;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] link_addr;
  logic            redirect_pending;
  logic            unused_alu_neg_q;

  // An op arriving while the redirect pulses is wrong-path and is refused;
  // a flush also blocks capture in its own cycle.
  assign in_ready       = (~out_valid | out_ready) & ~redirect_pending & ~flush;
  assign capture        = in_valid & in_ready;
  assign retire         = out_valid & out_ready & ~flush;
  assign link_addr      = pc + XLEN'(INSN_BYTES);
  assign redirect_valid = redirect_pending;

  alu_result_stage_branch_resolve #(
    .XLEN (XLEN)
  ) u_branch_resolve (
    .funct3   (br_funct3),
    .br_en    (br_en),
    .jal      (jal),
    .jalr     (jalr),
    .alu_zero (alu_zero),
    .alu_lsb  (alu_out[0]),
    .pc       (pc),
    .imm      (imm),
    .alu_out  (alu_out),
    .taken    (br_taken),
    .target   (br_target)
  );

  // Payload registers: load on capture, otherwise hold (stable across stalls).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result       <= '0;
      out_addr         <= '0;
      out_store_data   <= '0;
      out_rd           <= '0;
      out_reg_write    <= 1'b0;
      out_mem_read     <= 1'b0;
      out_mem_write    <= 1'b0;
      unused_alu_neg_q <= 1'b0;
    end else if (capture) begin
      out_result       <= (jal | jalr) ? link_addr : alu_out;
      out_addr         <= alu_out;
      out_store_data   <= store_data;
      out_rd           <= rd;
      out_reg_write    <= reg_write;
      out_mem_read     <= mem_read;
      out_mem_write    <= mem_write;
      unused_alu_neg_q <= alu_neg;
    end
  end

  // Valid bit and redirect pulse; the pulse only fires on the capture edge,
  // so a downstream stall cannot re-assert it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      redirect_pending <= 1'b0;
      redirect_pc      <= '0;
    end else if (flush) begin
      out_valid        <= 1'b0;
      redirect_pending <= 1'b0;
    end else if (capture) begin
      out_valid        <= 1'b1;
      redirect_pending <= br_taken;
      if (br_taken) begin
        redirect_pc <= br_target;
      end
    end else begin
      redirect_pending <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_retired <= '0;
      cnt_taken   <= '0;
    end else begin
      if (retire) begin
        cnt_retired <= cnt_retired + CNT_W'(1);
      end
      if (capture && br_taken) begin
        cnt_taken <= cnt_taken + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a scoreboard of expected payloads.
module tb_alu_result_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   alu_out;
  logic              alu_zero;
  logic              alu_neg;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   store_data;
  logic [4:0]        rd;
  logic              reg_write, mem_read, mem_write;
  logic              br_en;
  logic [2:0]        br_funct3;
  logic              jal, jalr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result, out_addr, out_store_data;
  logic [4:0]        out_rd;
  logic              out_reg_write, out_mem_read, out_mem_write;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic [CNT_W-1:0]  cnt_retired, cnt_taken;

  alu_result_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg), .pc(pc), .imm(imm),
    .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .br_en(br_en), .br_funct3(br_funct3), .jal(jal), .jalr(jalr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_addr(out_addr), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cnt_retired(cnt_retired), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic        neg;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br;
    logic [2:0]  f3;
    logic        jal, jalr;
  } op_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;
  int   exp_taken = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_taken(input op_t o);
    logic t;
    if (o.jal || o.jalr) t = 1'b1;
    else if (!o.br) t = 1'b0;
    else begin
      case (o.f3)
        3'b000: t = o.zero;
        3'b001: t = !o.zero;
        3'b100, 3'b110: t = o.alu[0];
        3'b101, 3'b111: t = !o.alu[0];
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

  function automatic logic [31:0] model_target(input op_t o);
    return o.jalr ? {o.alu[31:1], 1'b0} : o.pc + o.imm;
  endfunction

  function automatic exp_t model_out(input op_t o);
    exp_t e;
    e.result = (o.jal || o.jalr) ? o.pc + 32'd4 : o.alu;
    e.addr   = o.alu;
    e.sd     = o.sd;
    e.rd     = o.rd;
    e.rw     = o.rw;
    e.mr     = o.mr;
    e.mw     = o.mw;
    return e;
  endfunction

  task automatic drive(input op_t o);
    alu_out = o.alu; alu_zero = o.zero; alu_neg = o.neg; pc = o.pc; imm = o.imm;
    store_data = o.sd; rd = o.rd; reg_write = o.rw; mem_read = o.mr; mem_write = o.mw;
    br_en = o.br; br_funct3 = o.f3; jal = o.jal; jalr = o.jalr;
  endtask

  // Advance one clock. Before the edge, consume the scoreboard entry the DUT
  // is handing downstream (or discarding on flush) this cycle.
  task automatic step();
    exp_t e;
    if (!rst && out_valid) begin
      if (flush) begin
        chk("flush_sb_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) sb.delete(0);
      end else if (out_ready) begin
        chk("retire_sb_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_result", out_result, e.result);
          chk("out_addr", out_addr, e.addr);
          chk("out_store_data", out_store_data, e.sd);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write},
              {29'd0, e.rw, e.mr, e.mw});
          exp_retired++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one op that must be accepted, then check the redirect outcome.
  task automatic issue(input op_t o);
    logic tk;
    drive(o);
    in_valid = 1'b1;
    #1;
    chk("in_ready_accept", 32'(in_ready), 32'd1);
    tk = model_taken(o);
    sb.push_back(model_out(o));
    if (tk) exp_taken++;
    step();
    in_valid = 1'b0;
    chk("out_valid_capture", 32'(out_valid), 32'd1);
    chk("redirect_valid", 32'(redirect_valid), 32'(tk));
    if (tk) chk("redirect_pc", redirect_pc, model_target(o));
    chk("cnt_taken", cnt_taken, 32'(exp_taken));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    op_t o, w;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    o = '0;
    drive(o);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_cnt_retired", cnt_retired, 32'd0);
    chk("rst_cnt_taken", cnt_taken, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // BEQ taken, then a wrong-path op held during the redirect pulse
    o = '0; o.pc = 32'h100; o.imm = 32'h20; o.zero = 1'b1; o.br = 1'b1; o.f3 = 3'b000;
    o.sd = 32'hAAAA_0001; o.rd = 5'd3;
    issue(o);
    chk("beq_target", redirect_pc, 32'h120);
    chk("beq_cnt_taken", cnt_taken, 32'd1);
    w = '0; w.alu = 32'hDEAD_BEEF; w.rd = 5'd9; w.rw = 1'b1;
    drive(w);
    in_valid = 1'b1;
    #1;
    chk("wrong_path_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk("pulse_one_cycle", 32'(redirect_valid), 32'd0);
    chk("wrong_path_not_captured", 32'(out_valid), 32'd0);
    chk("cnt_retired_after_beq", cnt_retired, 32'(exp_retired));

    // BEQ not taken
    o.zero = 1'b0; o.alu = 32'h4; o.rd = 5'd4;
    issue(o);
    idle(1);

    // BLTU taken on slt result, BGE/010/011 not taken, back-to-back
    o = '0; o.pc = 32'h500; o.imm = 32'h80; o.alu = 32'h1; o.br = 1'b1; o.f3 = 3'b110;
    o.rd = 5'd5; o.rw = 1'b0;
    issue(o);
    idle(1);
    o.f3 = 3'b101; o.rd = 5'd6; o.sd = 32'h1234_5678;
    issue(o);
    o.f3 = 3'b010; o.alu = 32'h0; o.zero = 1'b1; o.rd = 5'd7; o.rw = 1'b1;
    issue(o);
    o.f3 = 3'b011; o.alu = 32'h1; o.rd = 5'd8; o.mr = 1'b1;
    issue(o);
    idle(1);

    // JALR: cleared LSB target, link result
    o = '0; o.alu = 32'h2003; o.pc = 32'h40; o.jalr = 1'b1; o.rw = 1'b1; o.rd = 5'd1;
    issue(o);
    chk("jalr_target", redirect_pc, 32'h2002);
    chk("jalr_link", out_result, 32'h44);
    chk("jalr_reg_write", 32'(out_reg_write), 32'd1);
    idle(1);

    // jal and jalr together: jalr target wins
    o = '0; o.alu = 32'h3001; o.pc = 32'h10; o.imm = 32'h100; o.jal = 1'b1; o.jalr = 1'b1;
    o.rd = 5'd2; o.rw = 1'b1;
    issue(o);
    chk("jal_jalr_target", redirect_pc, 32'h3000);
    idle(1);

    // JAL backwards, then JAL wrapping past the top of the address space
    o = '0; o.pc = 32'h200; o.imm = 32'hFFFF_FFF0; o.jal = 1'b1; o.rw = 1'b1; o.rd = 5'd10;
    o.alu = 32'h77;
    issue(o);
    chk("jal_back_target", redirect_pc, 32'h1F0);
    idle(1);
    o.pc = 32'hFFFF_FFFC; o.imm = 32'h8; o.rd = 5'd11;
    issue(o);
    chk("wrap_target", redirect_pc, 32'h4);
    chk("wrap_link", out_result, 32'h0);
    idle(1);

    // Stall after a taken BNE: one pulse, stable payload, no retire until ready
    out_ready = 1'b0;
    o = '0; o.pc = 32'h300; o.imm = 32'h40; o.alu = 32'h55; o.zero = 1'b0; o.br = 1'b1;
    o.f3 = 3'b001; o.sd = 32'hCAFE_F00D; o.rd = 5'd12; o.mw = 1'b1;
    issue(o);
    chk("stall_target", redirect_pc, 32'h340);
    w = '0; w.alu = 32'h9999; w.rd = 5'd13;
    for (int i = 0; i < 3; i++) begin
      drive(w);
      in_valid = 1'b1;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_result", out_result, sb[0].result);
      chk("stall_out_store_data", out_store_data, sb[0].sd);
      chk("stall_out_rd", 32'(out_rd), 32'(sb[0].rd));
      chk("stall_cnt_retired", cnt_retired, 32'(exp_retired));
      step();
      chk("stall_no_repulse", 32'(redirect_valid), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_released", 32'(out_valid), 32'd0);
    chk("stall_cnt_retired_after", cnt_retired, 32'(exp_retired));
    chk("stall_cnt_taken", cnt_taken, 32'(exp_taken));

    // Flush while an op is held: discarded, not counted, no capture
    out_ready = 1'b0;
    o = '0; o.alu = 32'h8000; o.sd = 32'h0BAD_0BAD; o.mw = 1'b1; o.rd = 5'd14;
    issue(o);
    drive(w);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_cnt_retired", cnt_retired, 32'(exp_retired));
    out_ready = 1'b1;
    idle(1);
    chk("flush_nothing_captured", 32'(out_valid), 32'd0);

    // Flush coincident with the redirect pulse
    o = '0; o.pc = 32'h600; o.imm = 32'h10; o.zero = 1'b1; o.br = 1'b1; o.f3 = 3'b000; o.rd = 5'd15;
    issue(o);
    flush = 1'b1;
    #1;
    chk("flush_pulse_visible", 32'(redirect_valid), 32'd1);
    step();
    flush = 1'b0;
    chk("flush_pulse_gone", 32'(redirect_valid), 32'd0);
    chk("flush_pulse_out_valid", 32'(out_valid), 32'd0);
    chk("flush_pulse_cnt_retired", cnt_retired, 32'(exp_retired));

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    o = '0; o.pc = 32'h700; o.imm = 32'h4; o.jal = 1'b1; o.rw = 1'b1; o.rd = 5'd16;
    issue(o);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("arst_redirect_pc", redirect_pc, 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    chk("arst_out_reg_write", 32'(out_reg_write), 32'd0);
    chk("arst_cnt_retired", cnt_retired, 32'd0);
    chk("arst_cnt_taken", cnt_taken, 32'd0);
    sb.delete();
    exp_retired = 0;
    exp_taken = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);

    // Normal operation resumes after reset
    o = '0; o.alu = 32'h1111; o.rd = 5'd17; o.rw = 1'b1;
    issue(o);
    idle(2);
    chk("final_cnt_retired", cnt_retired, 32'(exp_retired));
    chk("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
